// File: rtl/logic_unit.sv
// logic_unit: registered bitwise logic slice of a small datapath.
// The select code {s1,s0} picks one of AND / OR / XOR / NOT-A. The selected
// result and its all-zeros flag are loaded into output flops when en is
// high. D and zero come straight from flops, so no input reaches an output
// without passing through a clock edge. rst_n is asynchronous and active-low.
// It clears D to 0 and sets zero to 1 as soon as it falls. Deassertion must
// already be synchronized to clk upstream of this block.
module logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             s1,
  input  logic             s0,
  input  logic             en,
  output logic [WIDTH-1:0] D,
  output logic             zero
);

  // Operation encoding, matching the select code {s1,s0}.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_t;

  op_t              op;
  logic [WIDTH-1:0] f_next;
  logic             f_is_zero;

  assign op = op_t'({s1, s0});

  // Next result. The case covers all four codes, so no latch is inferred.
  // For NOT, operand B is ignored.
  always_comb begin
    f_next = '0;
    case (op)
      OP_AND:  f_next = A & B;
      OP_OR:   f_next = A | B;
      OP_XOR:  f_next = A ^ B;
      OP_NOT:  f_next = ~A;
      default: f_next = '0;
    endcase
  end

  // The zero flag is computed from the next value. It is then registered
  // together with D, so the two always describe the same loaded result.
  assign f_is_zero = (f_next == '0);

  // Result register. It loads on en and otherwise holds its value.
  // Reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D    <= '0;
      zero <= 1'b1;
    end else if (en) begin
      D    <= f_next;
      zero <= f_is_zero;
    end
  end

endmodule

// File: tb/tb_logic_unit.sv
// Directed and randomized checks for logic_unit (WIDTH = 8).
module tb_logic_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       s1;
  logic       s0;
  logic       en;
  logic [7:0] D;
  logic       zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  logic_unit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .s1   (s1),
    .s0   (s0),
    .en   (en),
    .D    (D),
    .zero (zero)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour taken from the operation table
  function automatic logic [7:0] ref_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] sel);
    case (sel)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] sel, input logic e);
    A  = a;
    B  = b;
    s1 = sel[1];
    s0 = sel[0];
    en = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)), 1'b1);
      tick();
      n_checks++;
      if (D !== 8'h00 || zero !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold: D=%h zero=%b, required D=00 zero=1", D, zero);
      end
    end
    rst_n = 1'b1;
    drive(8'hFF, 8'h00, 2'b01, 1'b1);
    tick();
    n_checks++;
    if (D !== 8'hFF || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL first_load: D=%h zero=%b, required D=ff zero=0", D, zero);
    end
    // Assert reset between edges; D must clear with no clock edge.
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (D !== 8'h00 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: D=%h zero=%b, required D=00 zero=1", D, zero);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_d[4];
    exp_d[0] = 8'h10;
    exp_d[1] = 8'hF4;
    exp_d[2] = 8'hE4;
    exp_d[3] = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      drive(8'hF0, 8'h14, 2'(i), 1'b1);
      tick();
      n_checks++;
      if (D !== exp_d[i] || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL op_sweep sel=%0d: D=%h zero=%b, required D=%h zero=0",
                 i, D, zero, exp_d[i]);
      end
    end
  endtask

  task automatic test_zero_flag();
    logic [7:0] va[3];
    logic [7:0] vb[3];
    logic [1:0] vs[3];
    va[0] = 8'hF0; vb[0] = 8'h0F; vs[0] = 2'b00;
    va[1] = 8'hFF; vb[1] = 8'h3C; vs[1] = 2'b11;
    va[2] = 8'h5A; vb[2] = 8'h5A; vs[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      // Load a nonzero value first, so that zero has to switch to 1.
      drive(8'h01, 8'h00, 2'b01, 1'b1);
      tick();
      drive(va[i], vb[i], vs[i], 1'b1);
      tick();
      n_checks++;
      if (D !== 8'h00 || zero !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_flag vec=%0d: D=%h zero=%b, required D=00 zero=1",
                 i, D, zero);
      end
    end
  endtask

  task automatic test_hold();
    drive(8'hF0, 8'h14, 2'b00, 1'b1);
    tick();
    n_checks++;
    if (D !== 8'h10) begin
      n_fail++;
      $display("FAIL hold_load: D=%h, required 10", D);
    end
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'(i + 1), 1'b0);
      tick();
      n_checks++;
      if (D !== 8'h10 || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL hold cycle=%0d: D=%h zero=%b, required D=10 zero=0", i, D, zero);
      end
    end
    drive(8'h33, 8'hC3, 2'b10, 1'b1);
    tick();
    n_checks++;
    if (D !== 8'hF0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: D=%h zero=%b, required D=f0 zero=0", D, zero);
    end
  endtask

  task automatic test_random();
    logic [7:0] model_d;
    logic [7:0] a, b, exp_d;
    logic [1:0] sel;
    logic       e;
    model_d = D;
    for (int i = 0; i < 1200; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      sel = 2'($urandom_range(0, 3));
      e   = ($urandom_range(0, 7) != 0);
      // Give the zero flag a fair chance of being exercised.
      if ($urandom_range(0, 15) == 0) b = (sel == 2'b10) ? a : ~a;
      if (e) model_d = ref_f(a, b, sel);
      exp_q.push_back(model_d);
      drive(a, b, sel, e);
      tick();
      exp_d = exp_q.pop_front();
      n_checks++;
      if (D !== exp_d || zero !== (exp_d == 8'h00)) begin
        n_fail++;
        $display("FAIL random i=%0d: D=%h zero=%b, required D=%h zero=%b",
                 i, D, zero, exp_d, (exp_d == 8'h00));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(8'hA5 + 8'(i), 8'h3C, 2'(i), 1'b1);
      tick();
      n_checks++;
      if (D !== ref_f(8'hA5 + 8'(i), 8'h3C, 2'(i))) begin
        n_fail++;
        $display("FAIL b2b i=%0d: D=%h, required %h", i, D,
                 ref_f(8'hA5 + 8'(i), 8'h3C, 2'(i)));
      end
    end
    drive(8'h0F, 8'hFF, 2'b01, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (D !== 8'h00 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: D=%h zero=%b, required D=00 zero=1", D, zero);
    end
    #2 rst_n = 1'b1;
    drive(8'h81, 8'h18, 2'b01, 1'b1);
    tick();
    n_checks++;
    if (D !== 8'h99 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_load: D=%h zero=%b, required D=99 zero=0", D, zero);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 2'b00, 1'b0);
    test_reset();
    test_op_sweep();
    test_zero_flag();
    test_hold();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
